mem_dma: RTL and testbench

- Master-side engine for the 256-byte single-port data memory. It drives address, write_enable and write_data, and samples read_data.
- Performs block copy (memory to memory) or block fill (constant to memory) on request from the CPU control path.
- Signals completion with a start/busy/done handshake.
- Sits between the CPU control unit and the memory port; while busy, the CPU does not drive the memory port (the arbitration mux is outside this block).

---
 rtl/mem_dma_pkg.sv | 19 +
 rtl/mem_dma.sv | 159 +++++++++++++++
 tb/tb_mem_dma.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory DMA engine: state encoding, mode values
// and the default memory geometry also used by the memory and the CPU.
package mem_dma_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StWrite = 3'd2,
        StFill  = 3'd3,
        StDone  = 3'd4
    } dma_state_e;

endpackage

// File: rtl/mem_dma.sv
// Memory DMA engine: block copy (read then write, one byte at a time) or block
// fill into a single-port memory with combinational reads. All outputs come
// straight from registers, so they never depend on the request inputs.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    // One bit wider than the address so that a 256-byte request stays nonzero.
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] fill_q, fill_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              last_byte;

    assign last_byte = (rem_q == (ADDR_W+1)'(1));

    // Next-state for the FSM and datapath, then output decode from the next state
    // so the output registers line up with the state they describe.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        fill_d  = fill_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = length;
                    fill_d = fill_value;
                    if (length == '0) begin
                        state_d = StDone;
                    end else if (mode == MODE_FILL) begin
                        state_d = StFill;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                data_d  = mem_read_data;
                state_d = StWrite;
            end
            StWrite: begin
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = last_byte ? StDone : StRead;
            end
            StFill: begin
                dst_d   = dst_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = last_byte ? StDone : StFill;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d  = 1'b0;
        done_d  = 1'b0;
        addr_d  = '0;
        we_d    = 1'b0;
        wdata_d = '0;
        case (state_d)
            StRead: begin
                busy_d = 1'b1;
                addr_d = src_d;
            end
            StWrite: begin
                busy_d  = 1'b1;
                addr_d  = dst_d;
                we_d    = 1'b1;
                wdata_d = data_d;
            end
            StFill: begin
                busy_d  = 1'b1;
                addr_d  = dst_d;
                we_d    = 1'b1;
                wdata_d = fill_d;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything at once so a
    // write in flight is dropped before the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign mem_address      = addr_q;
    assign mem_write_enable = we_q;
    assign mem_write_data   = wdata_q;

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a 256-byte combinational-read memory model.
module tb_mem_dma;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] length;
    logic [7:0] fill_value;
    logic       busy;
    logic       done;
    logic [7:0] mem_address;
    logic       mem_write_enable;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;

    logic [7:0] mem [256];
    logic [7:0] rd_log [$];

    int total = 0;
    int bad   = 0;

    mem_dma #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
        .fill_value       (fill_value),
        .busy             (busy),
        .done             (done),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at the rising edge.
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] = mem_write_data;
    end

    // Log every read-phase address.
    always @(negedge clk) begin
        if (busy && !mem_write_enable) rd_log.push_back(mem_address);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [8:0] len, input logic [7:0] f);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; length = len; fill_value = f; start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        mode       = ~m;
        src_addr   = 8'($urandom);
        dst_addr   = 8'($urandom);
        length     = 9'($urandom);
        fill_value = 8'($urandom);
    endtask

    // Counts cycles after the accept edge up to and including the done cycle.
    task automatic wait_done(input string tag, output int cyc, output int busy_n,
                             output int we_n, output int adj);
        logic prev_we = 1'b0;
        logic seen    = 1'b0;
        cyc = 0; busy_n = 0; we_n = 0; adj = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (mem_write_enable) begin
                we_n++;
                if (prev_we) adj++;
            end
            prev_we = mem_write_enable;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_idle_we"}, 32'(mem_write_enable), 32'd0);
    endtask

    initial begin
        int cyc, busy_n, we_n, adj, errs;

        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_value = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_write_enable), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", 32'(mem_write_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill 4 bytes at 0x10
        mem[8'h14] = 8'h5A;
        do_start(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5);
        wait_done("fill", cyc, busy_n, we_n, adj);
        chk("fill_latency", 32'(cyc), 32'd5);
        chk("fill_busy_cycles", 32'(busy_n), 32'd4);
        chk("fill_we_cycles", 32'(we_n), 32'd4);
        for (int i = 0; i < 4; i++) chk("fill_data", 32'(mem[8'h10 + i]), 32'hA5);
        chk("fill_past_end", 32'(mem[8'h14]), 32'h5A);

        // Copy 3 bytes 0x20 -> 0x40
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33; mem[8'h43] = 8'hEE;
        do_start(1'b0, 8'h20, 8'h40, 9'd3, 8'h00);
        wait_done("copy", cyc, busy_n, we_n, adj);
        chk("copy_latency", 32'(cyc), 32'd7);
        chk("copy_we_cycles", 32'(we_n), 32'd3);
        chk("copy_we_alternate", 32'(adj), 32'd0);
        chk("copy_b0", 32'(mem[8'h40]), 32'h11);
        chk("copy_b1", 32'(mem[8'h41]), 32'h22);
        chk("copy_b2", 32'(mem[8'h42]), 32'h33);
        chk("copy_past_end", 32'(mem[8'h43]), 32'hEE);

        // Full 256-byte fill starting near the top of memory
        do_start(1'b1, 8'h00, 8'hFE, 9'd256, 8'h3C);
        wait_done("wrapfill", cyc, busy_n, we_n, adj);
        chk("wrapfill_latency", 32'(cyc), 32'd257);
        chk("wrapfill_we_cycles", 32'(we_n), 32'd256);
        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 8'h3C) errs++;
        chk("wrapfill_all_bytes", 32'(errs), 32'd0);

        // Copy across the address wrap
        mem[8'hFF] = 8'hAB; mem[8'h00] = 8'hCD; mem[8'h01] = 8'h00;
        rd_log.delete();
        do_start(1'b0, 8'hFF, 8'h00, 9'd2, 8'h00);
        wait_done("wrapcopy", cyc, busy_n, we_n, adj);
        chk("wrapcopy_latency", 32'(cyc), 32'd5);
        chk("wrapcopy_nreads", 32'(rd_log.size()), 32'd2);
        chk("wrapcopy_rd0", 32'(rd_log[0]), 32'hFF);
        chk("wrapcopy_rd1", 32'(rd_log[1]), 32'h00);
        chk("wrapcopy_b0", 32'(mem[8'h00]), 32'hAB);
        chk("wrapcopy_b1", 32'(mem[8'h01]), 32'hAB);

        // Zero length
        do_start(1'b1, 8'h00, 8'h30, 9'd0, 8'h99);
        wait_done("zero", cyc, busy_n, we_n, adj);
        chk("zero_latency", 32'(cyc), 32'd1);
        chk("zero_busy", 32'(busy_n), 32'd0);
        chk("zero_we", 32'(we_n), 32'd0);
        chk("zero_mem", 32'(mem[8'h30]), 32'h3C);

        // Overlapping copy with a start pulse mid-transfer
        mem[8'h50] = 8'h77; mem[8'h51] = 8'h01; mem[8'h52] = 8'h02; mem[8'h53] = 8'h03;
        mem[8'h54] = 8'h04; mem[8'h90] = 8'h12;
        do_start(1'b0, 8'h50, 8'h51, 9'd3, 8'h00);
        @(negedge clk);
        chk("ovl_busy_c1", 32'(busy), 32'd1);
        mode = 1'b1; dst_addr = 8'h90; length = 9'd5; fill_value = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ovl_busy_c2", 32'(busy), 32'd1);
        wait_done("ovl", cyc, busy_n, we_n, adj);
        chk("ovl_latency_rest", 32'(cyc), 32'd5);
        chk("ovl_b1", 32'(mem[8'h51]), 32'h77);
        chk("ovl_b2", 32'(mem[8'h52]), 32'h77);
        chk("ovl_b3", 32'(mem[8'h53]), 32'h77);
        chk("ovl_past_end", 32'(mem[8'h54]), 32'h04);
        chk("ovl_ignored_fill", 32'(mem[8'h90]), 32'h12);

        // Reset during the third WRITE of an 8-byte copy
        for (int i = 0; i < 8; i++) begin
            mem[8'h60 + i] = 8'(i + 1);
            mem[8'h70 + i] = 8'hEE;
        end
        do_start(1'b0, 8'h60, 8'h70, 9'd8, 8'h00);
        repeat (6) @(negedge clk);
        chk("rstmid_third_write_we", 32'(mem_write_enable), 32'd1);
        chk("rstmid_third_write_addr", 32'(mem_address), 32'h72);
        rst = 1'b1;
        #1;
        chk("rstmid_we", 32'(mem_write_enable), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_addr", 32'(mem_address), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("rstmid_done_hold", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_after_done", 32'(done), 32'd0);
            chk("rstmid_after_busy", 32'(busy), 32'd0);
        end
        chk("rstmid_b0", 32'(mem[8'h70]), 32'h01);
        chk("rstmid_b1", 32'(mem[8'h71]), 32'h02);
        chk("rstmid_b2", 32'(mem[8'h72]), 32'hEE);
        chk("rstmid_b7", 32'(mem[8'h77]), 32'hEE);

        // New fill after reset
        do_start(1'b1, 8'h00, 8'hA0, 9'd2, 8'h99);
        wait_done("postrst", cyc, busy_n, we_n, adj);
        chk("postrst_latency", 32'(cyc), 32'd3);
        chk("postrst_b0", 32'(mem[8'hA0]), 32'h99);
        chk("postrst_b1", 32'(mem[8'hA1]), 32'h99);
        chk("postrst_past_end", 32'(mem[8'hA2]), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
